// File: rtl/mem_pkg.sv
// mem_pkg
//
// Shared definitions for the memory-stage SRAM controller:
//   mem_state_t       - controller FSM states (IDLE, LOW, HIGH, DONE)
//   HALF_LO / HALF_HI - value of the half-word select bit in the SRAM address
//   DEFAULT_BASE_ADDR - byte address that maps to SRAM half-word 0
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
//
// Memory-stage controller. It performs 32-bit loads and stores on a 16-bit
// external SRAM as two half-word accesses (low half, then high half), and
// freezes the pipeline until the access completes.
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   MEM_R_EN      - load request (held while freeze=1)
//   MEM_W_EN      - store request (held while freeze=1), wins over MEM_R_EN
//   ALU_result    - byte address of the access
//   ST_val        - store data
//   read_data     - last completed load word (registered)
//   ready         - access complete, or nothing pending
//   freeze        - ~ready, stalls the upstream pipeline
//   sram_addr     - half-word address (registered)
//   sram_dq_out   - write data (registered)
//   sram_dq_oe    - data bus drive enable (registered)
//   sram_dq_in    - read data from SRAM
//   sram_we_n     - active-low write strobe (registered)
//   sram_oe_n     - active-low output enable (registered)
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;

  logic              req;
  logic              phase_last;
  logic              in_access;
  logic              half;
  logic [31:0]       off;
  logic              unused_off_bits;

  assign req        = MEM_R_EN | MEM_W_EN;
  assign phase_last = (cnt_q == CNT_LAST);
  assign off        = ALU_result - 32'(BASE_ADDR);

  // Byte offset within the word and address bits above the SRAM are dropped,
  // so out-of-range addresses simply wrap.
  assign unused_off_bits = ^{off[31:ADDR_W+1], off[1:0]};

  // State, counter, latched direction and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      read_data_q <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // Next state: each half-word phase lasts WAIT_CYCLES+1 cycles. The access
  // direction is latched on leaving IDLE so a dropped request still completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
          store_d = MEM_W_EN;
        end
      end
      LOW: begin
        if (phase_last) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM controls are derived from the upcoming state so the registered pins
  // line up with the state they belong to. The write strobe is released on
  // the last cycle of each phase to give address/data hold.
  always_comb begin
    in_access   = (state_d == LOW) || (state_d == HIGH);
    half        = (state_d == HIGH) ? HALF_HI : HALF_LO;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    read_data_d = read_data_q;

    if (in_access) begin
      addr_d  = {off[ADDR_W:2], half};
      dq_oe_d = store_d;
      oe_n_d  = store_d;
      if (store_d) begin
        dq_out_d = (half == HALF_HI) ? ST_val[31:16] : ST_val[15:0];
        we_n_d   = (cnt_d == CNT_LAST);
      end
    end

    // Load data is captured at the end of each phase's final cycle.
    if (!store_q && phase_last) begin
      if (state_q == LOW) begin
        read_data_d[15:0] = sram_dq_in;
      end
      if (state_q == HIGH) begin
        read_data_d[31:16] = sram_dq_in;
      end
    end
  end

  assign ready       = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign freeze      = ~ready;
  assign read_data   = read_data_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl
//
// Bench for mem_sram_ctrl. Instance 1 runs with one wait cycle and a
// behavioural SRAM; instance 0 runs with no wait cycles.
module tb_mem_sram_ctrl;

  localparam int BASE   = 1024;
  localparam int ADDR_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        rEn   [2];
  logic        wEn   [2];
  logic [31:0] alu   [2];
  logic [31:0] st    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        frz   [2];
  logic [17:0] sAddr [2];
  logic [15:0] dqOut [2];
  logic [15:0] dqIn  [2];
  logic        dqOe  [2];
  logic        weN   [2];
  logic        oeN   [2];

  logic [15:0] sram1  [DEPTH];
  logic [15:0] refMem [DEPTH];
  logic [31:0] expRead [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(0), .ADDR_W(ADDR_W)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(rEn[0]), .MEM_W_EN(wEn[0]),
    .ALU_result(alu[0]), .ST_val(st[0]), .read_data(rdata[0]),
    .ready(rdy[0]), .freeze(frz[0]), .sram_addr(sAddr[0]),
    .sram_dq_out(dqOut[0]), .sram_dq_oe(dqOe[0]), .sram_dq_in(dqIn[0]),
    .sram_we_n(weN[0]), .sram_oe_n(oeN[0])
  );

  mem_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(1), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(rEn[1]), .MEM_W_EN(wEn[1]),
    .ALU_result(alu[1]), .ST_val(st[1]), .read_data(rdata[1]),
    .ready(rdy[1]), .freeze(frz[1]), .sram_addr(sAddr[1]),
    .sram_dq_out(dqOut[1]), .sram_dq_oe(dqOe[1]), .sram_dq_in(dqIn[1]),
    .sram_we_n(weN[1]), .sram_oe_n(oeN[1])
  );

  // Behavioural SRAM for instance 1: writes while the strobe is low,
  // drives read data only while output enable is low.
  always @(posedge clk) begin
    if (!weN[1] && dqOe[1]) sram1[sAddr[1]] <= dqOut[1];
  end

  always @(negedge clk) begin
    dqIn[1] = !oeN[1] ? sram1[sAddr[1]] : 16'($urandom);
    dqIn[0] = 16'($urandom);
  end

  // One complete access on instance sel with wait count w; checks every
  // cycle against the expected waveform and the reference memory.
  task automatic applyStimulus(input int sel, input int w, input logic r, input logic wr,
                               input logic [31:0] a, input logic [31:0] s);
    logic [31:0] offs;
    logic [16:0] word;
    logic        lo;
    int          pos;
    logic [20:0] act, exp;
    logic [31:0] expR;
    offs = a - BASE;
    word = offs[ADDR_W:2];
    @(posedge clk); #1;
    rEn[sel] = r; wEn[sel] = wr; alu[sel] = a; st[sel] = s;
    @(negedge clk);
    checks++;
    if ({rdy[sel], frz[sel], weN[sel], oeN[sel], dqOe[sel]} !== 5'b01110) begin
      errors++;
      $display("[TB] FAIL req_idle: got %b expected 01110", {rdy[sel], frz[sel], weN[sel], oeN[sel], dqOe[sel]});
    end
    for (int k = 1; k <= 2 * w + 3; k++) begin
      @(negedge clk);
      checks++;
      if ($isunknown({rdata[sel], rdy[sel], frz[sel], sAddr[sel], dqOut[sel], dqOe[sel], weN[sel], oeN[sel]})) begin
        errors++;
        $display("[TB] FAIL x_outputs: cycle %0d got unknown output value", k);
      end
      if (k <= 2 * w + 2) begin
        lo  = (k <= w + 1);
        pos = lo ? k - 1 : k - w - 2;
        act = {rdy[sel], sAddr[sel], oeN[sel], dqOe[sel]};
        exp = {1'b0, word, ~lo, wr, wr};
        checks++;
        if (act !== exp || weN[sel] !== (wr ? (pos == w) : 1'b1)) begin
          errors++;
          $display("[TB] FAIL phase_ctrl: cycle %0d got %h we_n %b expected %h we_n %b",
                   k, act, weN[sel], exp, wr ? (pos == w) : 1'b1);
        end
        if (wr) begin
          checks++;
          if (dqOut[sel] !== (lo ? s[15:0] : s[31:16])) begin
            errors++;
            $display("[TB] FAIL store_data: cycle %0d got %h expected %h", k, dqOut[sel], lo ? s[15:0] : s[31:16]);
          end
        end
      end else begin
        expR = wr ? expRead[sel] : {refMem[{word, 1'b1}], refMem[{word, 1'b0}]};
        checks++;
        if (rdy[sel] !== 1'b1 || frz[sel] !== 1'b0 || rdata[sel] !== expR) begin
          errors++;
          $display("[TB] FAIL done: ready %b freeze %b read_data %h expected 1 0 %h", rdy[sel], frz[sel], rdata[sel], expR);
        end
        expRead[sel] = expR;
        if (wr && sel == 1 && w > 0) begin
          refMem[{word, 1'b0}] = s[15:0];
          refMem[{word, 1'b1}] = s[31:16];
        end
      end
    end
  endtask

  // Drop the request for n cycles and confirm the controller sits idle.
  task automatic checkOutput(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rEn[sel] = 1'b0; wEn[sel] = 1'b0;
      @(negedge clk);
      checks++;
      if ({rdy[sel], frz[sel], weN[sel], oeN[sel], dqOe[sel]} !== 5'b10110 || rdata[sel] !== expRead[sel]) begin
        errors++;
        $display("[TB] FAIL idle: got %b rd %h expected 10110 rd %h",
                 {rdy[sel], frz[sel], weN[sel], oeN[sel], dqOe[sel]}, rdata[sel], expRead[sel]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({rdata[1], sAddr[1], dqOut[1], dqOe[1], weN[1], oeN[1], rdy[1], frz[1]} !==
        {32'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: rd %h addr %h dq %h oe %b we_n %b oe_n %b ready %b",
               rdata[1], sAddr[1], dqOut[1], dqOe[1], weN[1], oeN[1], rdy[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    checkOutput(1, 2);
  endtask

  task automatic test_load();
    sram1[4] = 16'h1234;  sram1[5] = 16'hABCD;
    refMem[4] = 16'h1234; refMem[5] = 16'hABCD;
    applyStimulus(1, 1, 1'b1, 1'b0, 32'd1032, 32'h0);
    checks++;
    if (rdata[1] !== 32'hABCD1234) begin
      errors++;
      $display("[TB] FAIL load_word: got %h expected abcd1234", rdata[1]);
    end
    checkOutput(1, 1);
  endtask

  task automatic test_store();
    applyStimulus(1, 1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    checkOutput(1, 1);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 1, 1'b0, 1'b1, 32'd1036, 32'hDEADBEEF);
    applyStimulus(1, 1, 1'b1, 1'b0, 32'd1036, 32'h0);
    checks++;
    if (rdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL b2b_load: got %h expected deadbeef", rdata[1]);
    end
    checkOutput(1, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          dir;
    for (int i = 0; i < 30; i++) begin
      a   = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      dir = $urandom_range(0, 2);
      applyStimulus(1, 1, dir != 1, dir != 0, a, $urandom);
      checkOutput(1, $urandom_range(0, 2));
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1, 1, 1'b1, 1'b0, 32'd1036, 32'h0);
    @(posedge clk); #1;
    rEn[1] = 1'b1; wEn[1] = 1'b0; alu[1] = 32'd1040;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({rdata[1], sAddr[1], dqOut[1], dqOe[1], weN[1], oeN[1]} !==
        {32'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL async_reset: rd %h addr %h dq %h oe %b we_n %b oe_n %b",
               rdata[1], sAddr[1], dqOut[1], dqOe[1], weN[1], oeN[1]);
    end
    rEn[1] = 1'b0;
    #1;
    checks++;
    if (rdy[1] !== 1'b1 || frz[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: ready %b freeze %b expected 1 0", rdy[1], frz[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    expRead[0] = 32'h0;
    expRead[1] = 32'h0;
    @(negedge clk);
    checks++;
    if (rdata[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_read_data: got %h expected 0", rdata[1]);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(1, 1, 1'b0, 1'b1, 32'd1020, 32'h5A5AC3C3);
    applyStimulus(1, 1, 1'b1, 1'b0, 32'd1020, 32'h0);
    checkOutput(1, 1);
  endtask

  task automatic test_both_w0();
    applyStimulus(0, 0, 1'b1, 1'b1, 32'd1048, 32'hCAFEF00D);
    checkOutput(0, 1);
    applyStimulus(0, 0, 1'b1, 1'b1, 32'd1020, 32'h01020304);
    checkOutput(0, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram1[i]  = 16'(i * 40503) ^ 16'h5A5A;
      refMem[i] = 16'(i * 40503) ^ 16'h5A5A;
    end
    for (int s = 0; s < 2; s++) begin
      rEn[s] = 1'b0; wEn[s] = 1'b0; alu[s] = 32'h0; st[s] = 32'h0; expRead[s] = 32'h0;
    end
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_wrap();
    test_both_w0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
